// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage and its IF/ID register.
package if_id_fetch_stage_pkg;

   localparam int unsigned W = 32;
   localparam logic [W-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [W-1:0] NOP      = 32'h0000_0000;
   localparam logic [W-1:0] PC_INC   = 32'd4;

   // Branch/jump targets are word addresses; the two byte-offset bits are dropped.
   function automatic logic [W-1:0] align_word(input logic [W-1:0] addr);
      return {addr[W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_id_fetch_stage_if.sv
// Handshake bundle between the fetch stage and the rest of the core (hazard unit, ID, imem).
interface if_id_fetch_stage_if;
   import if_id_fetch_stage_pkg::*;

   logic         stall;
   logic         flush;
   logic         redirect;
   logic [W-1:0] redirect_target;
   logic [W-1:0] imem_addr;
   logic [W-1:0] imem_data;
   logic [W-1:0] pc;
   logic [W-1:0] if_id_instr;
   logic [W-1:0] if_id_pc4;
   logic         if_id_valid;

   modport master (
      output stall, flush, redirect, redirect_target, imem_data,
      input  imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid
   );

   modport slave (
      input  stall, flush, redirect, redirect_target, imem_data,
      output imem_addr, pc, if_id_instr, if_id_pc4, if_id_valid
   );

endinterface

// File: rtl/if_id_fetch_stage_pipe_reg_en.sv
// N-bit pipeline register with load enable and synchronous clear to a fixed value.
module if_id_fetch_stage_pipe_reg_en #(
   parameter int unsigned     N       = 32,
   parameter logic [N-1:0]    CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // Clear dominates enable so reset/flush always win over a stall hold.
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= CLR_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC register driving imem, plus the IF/ID register feeding decode.
module if_id_fetch_stage
   import if_id_fetch_stage_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   if_id_fetch_stage_if.slave bus
);

   logic [W-1:0] pc_q;
   logic [W-1:0] pc_plus4;
   logic [W-1:0] pc_d;
   logic         pc_en;
   logic         ifid_clr;
   logic         ifid_en;

   // One adder serves both the sequential PC and the latched PC+4.
   assign pc_plus4 = pc_q + PC_INC;
   assign pc_d     = bus.redirect ? align_word(bus.redirect_target) : pc_plus4;
   assign pc_en    = !bus.stall || bus.redirect;
   assign ifid_clr = reset || bus.flush;
   assign ifid_en  = !bus.stall;

   assign bus.pc        = pc_q;
   assign bus.imem_addr = pc_q;

   if_id_fetch_stage_pipe_reg_en #(.N(W), .CLR_VAL(RESET_PC)) u_pc (
      .clk (clk),
      .clr (reset),
      .en  (pc_en),
      .d   (pc_d),
      .q   (pc_q)
   );

   if_id_fetch_stage_pipe_reg_en #(.N(W), .CLR_VAL(NOP)) u_if_id_instr (
      .clk (clk),
      .clr (ifid_clr),
      .en  (ifid_en),
      .d   (bus.imem_data),
      .q   (bus.if_id_instr)
   );

   if_id_fetch_stage_pipe_reg_en #(.N(W), .CLR_VAL('0)) u_if_id_pc4 (
      .clk (clk),
      .clr (ifid_clr),
      .en  (ifid_en),
      .d   (pc_plus4),
      .q   (bus.if_id_pc4)
   );

   if_id_fetch_stage_pipe_reg_en #(.N(1), .CLR_VAL(1'b0)) u_if_id_valid (
      .clk (clk),
      .clr (ifid_clr),
      .en  (ifid_en),
      .d   (1'b1),
      .q   (bus.if_id_valid)
   );

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed plan scenarios followed by a random phase.
module tb_if_id_fetch_stage;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   exp_t sb[$];
   exp_t m;

   if_id_fetch_stage_if bus ();

   if_id_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] imem(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: return 32'h2001_0005;
         32'h0000_0004: return 32'h2002_0007;
         32'h0000_0008: return 32'h0022_1820;
         default:       return {addr[15:0], ~addr[15:0]};
      endcase
   endfunction

   always_comb bus.imem_data = imem(bus.imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, predict the post-edge state, then compare after the edge.
   task automatic step(input logic r, input logic s, input logic f, input logic rd,
                       input logic [31:0] tgt);
      exp_t e;
      @(negedge clk);
      reset               = r;
      bus.stall           = s;
      bus.flush           = f;
      bus.redirect        = rd;
      bus.redirect_target = tgt;
      if (r) begin
         e.pc = 32'h0; e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
      end else begin
         if (rd)     e.pc = {tgt[31:2], 2'b00};
         else if (s) e.pc = m.pc;
         else        e.pc = m.pc + 32'd4;
         if (f) begin
            e.instr = 32'h0; e.pc4 = 32'h0; e.valid = 1'b0;
         end else if (s) begin
            e.instr = m.instr; e.pc4 = m.pc4; e.valid = m.valid;
         end else begin
            e.instr = imem(m.pc); e.pc4 = m.pc + 32'd4; e.valid = 1'b1;
         end
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("pc",        bus.pc,          e.pc);
      chk("imem_addr", bus.imem_addr,   e.pc);
      chk("instr",     bus.if_id_instr, e.instr);
      chk("pc4",       bus.if_id_pc4,   e.pc4);
      chk("valid",     32'(bus.if_id_valid), 32'(e.valid));
      m = e;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m = '{pc: 32'h0, instr: 32'h0, pc4: 32'h0, valid: 1'b0};
      reset = 1'b1;
      bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 32'h0;

      // Reset and first fetches
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234_5678);
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_valid", 32'(bus.if_id_valid), 32'h0);
      run(2);
      chk("free_pc8", bus.pc, 32'h8);
      chk("free_instr", bus.if_id_instr, 32'h2002_0007);

      // Stall two cycles at pc=8, then release
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("stall_pc", bus.pc, 32'h8);
      chk("stall_pc4", bus.if_id_pc4, 32'h8);
      run(1);
      chk("rel_pc", bus.pc, 32'hC);
      chk("rel_instr", bus.if_id_instr, 32'h0022_1820);
      run(1);

      // Taken branch at pc=0x10
      chk("br_from", bus.pc, 32'h10);
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
      chk("br_pc", bus.pc, 32'h40);
      chk("br_bubble", 32'(bus.if_id_valid), 32'h0);
      run(1);
      chk("br_instr", bus.if_id_instr, imem(32'h40));
      chk("br_pc4", bus.if_id_pc4, 32'h44);

      // Redirect+stall+flush with misaligned target
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h83);
      chk("rsf_pc", bus.pc, 32'h80);
      chk("rsf_valid", 32'(bus.if_id_valid), 32'h0);
      run(1);

      // Delay-slot redirect to the top word, then wrap
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      chk("ds_valid", 32'(bus.if_id_valid), 32'h1);
      run(1);
      chk("wrap_pc", bus.pc, 32'h0);
      chk("wrap_pc4", bus.if_id_pc4, 32'h0);
      run(1);

      // Reset during stall at pc=0x24, and during a redirect
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h24);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("pre_rst_pc", bus.pc, 32'h24);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk("rst_stall_pc", bus.pc, 32'h0);
      chk("rst_stall_valid", 32'(bus.if_id_valid), 32'h0);
      run(2);
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
      chk("rst_redir_pc", bus.pc, 32'h0);

      // Random mix of controls
      for (int i = 0; i < 80; i++) begin
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS subset core.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched instruction and PC+4 into the IF/ID register consumed by decode.
- Honours stall from the hazard unit, and flush/redirect from branch/jump resolution in ID.

Parameters:
- W, 32, datapath width of PC and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0000, bubble encoding inserted on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID contents.
- flush  in  1  squash instruction currently being fetched (replace with bubble).
- redirect  in  1  load PC from redirect_target.
- redirect_target  in  W  branch/jump target.
- imem_addr  out  W  equals pc (combinational from PC register).
- imem_data  in  W  instruction at imem_addr, combinational same cycle.
- pc  out  W  current fetch PC.
- if_id_instr  out  W  latched instruction for decode.
- if_id_pc4  out  W  latched PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (sampled at posedge): pc=RESET_PC, if_id_instr=NOP, if_id_pc4=0, if_id_valid=0. Reset overrides every other input.
- First cycle after reset: imem_addr=RESET_PC. The first valid instruction appears in IF/ID after the following edge.
- Latency: instruction fetched at pc in cycle N is visible on if_id_* during cycle N+1.
- PC next-state, priority order:
  - reset: RESET_PC.
  - redirect: {redirect_target[W-1:2],2'b00}; low bits are forced to 0.
  - stall: hold.
  - otherwise: pc+4, modulo 2^W. 32'hFFFF_FFFC wraps to 0 with no flag.
- IF/ID next-state, priority order:
  - reset: bubble.
  - flush: bubble (instr=NOP, pc4=0, valid=0).
  - stall: hold all three fields unchanged.
  - otherwise: instr=imem_data, pc4=pc+4 (same wrap), valid=1.
- Simultaneous events:
  - redirect+stall: PC takes the target. Stall only holds IF/ID.
  - flush+stall: flush wins and IF/ID becomes a bubble.
  - flush+redirect: normal taken-branch case. PC gets the target and IF/ID gets a bubble.
  - redirect without flush: legal (delay-slot mode). The instruction fetched this cycle enters IF/ID as valid.
- Reset asserted mid-stall or mid-redirect: reset result at that edge, no residue.
- No internal FSM beyond the PC/IF-ID registers. All state updates only at posedge clk.
- No combinational path from stall/flush/redirect to if_id_*. imem_addr depends only on the PC register.

Decomposition:
- Shared package/header: W, RESET_PC, NOP, PC_INC=4.
- One natural sub-module: pipe_reg_en (N-bit register with enable and synchronous clear-to-value).
  - Instantiated for pc, if_id_instr, if_id_pc4, if_id_valid.
  - Enable = !stall, or redirect for the PC instance.
  - Clear = reset, or flush for the IF/ID instances.
- The PC+4 adder is inline. It is reused for both the PC update and if_id_pc4.

Test Plan:
- Reset then 3 free-running cycles, imem returns 0x2001_0005/0x2002_0007/0x0022_1820:
  - pc goes 0→4→8→C.
  - if_id_instr follows one cycle later.
  - if_id_pc4 = 4, 8, C.
  - valid = 0, 1, 1, 1.
- Stall held 2 cycles at pc=8:
  - pc stays 8.
  - IF/ID stays {0x2002_0007, 8, 1}.
  - After release, pc=C and IF/ID loads the 8-address instruction.
- flush+redirect target=0x40 at pc=0x10:
  - Next cycle pc=0x40, IF/ID = {NOP, 0, 0}.
  - Following cycle IF/ID = {imem[0x40], 0x44, 1}.
- redirect+stall+flush together with target=0x83:
  - pc=0x80 (low bits cleared).
  - IF/ID becomes a bubble despite stall.
- Wrap: redirect to 0xFFFF_FFFC, then free-run.
  - pc goes 0xFFFF_FFFC→0.
  - if_id_pc4 = 0.
- Reset asserted during stall with pc=0x24:
  - Next cycle pc=0, IF/ID bubble, valid=0.
